drum_timing: RTL and testbench
==============================

DRUM_TIMING -- requirements
Module: drum_timing

Interface
REQ-001 Parameter: WORDS, default 108, words per drum revolution.
REQ-002 Parameter: BITS, default 29, bit times per word (T1..T29).
REQ-003 Port: CLOCK  input  1  bit-time clock; all state changes on rising edge; one clock; reset is synchronous and active-high.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: SYNC  input  1  drum origin mark; forces counters to origin.
REQ-006 Port: LOC_LOAD  input  1  request: wait for word location LOC.
REQ-007 Port: LOC  input  7  target word location, 0..WORDS-1.
REQ-008 Port: LOC_CANCEL  input  1  abandon pending wait.
REQ-009 Port: TB  output  5  bit counter, 0..BITS-1 (0 = T1).
REQ-010 Port: TW  output  7  word counter, 0..WORDS-1.
REQ-011 Port: T1, T2, T29  output  1 each  decodes TB==0, TB==1, TB==BITS-1.
REQ-012 Port: CE  output  1  even word time, ~TW[0].
REQ-013 Port: ORIGIN  output  1  TW==0 & TB==0.
REQ-014 Port: LOC_BUSY  output  1  wait pending.
REQ-015 Port: LOC_HIT  output  1  one-cycle pulse, target word reached.
REQ-016 Port: LOC_ERR  output  1  sticky, out-of-range LOC requested.

Function
REQ-017 TB SHALL increment by 1 each cycle and wrap from BITS-1 to 0.
REQ-018 TW SHALL increment by 1 in the cycle TB wraps (TB==BITS-1) and wrap from WORDS-1 to 0; revolution = WORDS*BITS = 3132 cycles.
REQ-019 SYNC high at edge k SHALL give TB=0, TW=0 at cycle k+1, overriding increment; SYNC at ORIGIN is a no-op.
REQ-020 T1, T2, T29, CE, ORIGIN SHALL be pure decodes of the TB/TW registers, no extra latency.
REQ-021 Location FSM states: IDLE, WAIT; encoding free.
REQ-022 IDLE -> WAIT at edge where LOC_LOAD=1, LOC_CANCEL=0, LOC<WORDS; LOC captured into target register.
REQ-023 LOC_LOAD with LOC>=WORDS SHALL leave state unchanged and set LOC_ERR at next cycle; LOC_ERR cleared only by rst or next valid LOC_LOAD.
REQ-024 LOC_BUSY SHALL equal (state==WAIT).
REQ-025 LOC_HIT SHALL be high exactly in a cycle where state==WAIT, TW==target, TB==0; FSM -> IDLE at that edge.
REQ-026 Hit requires WAIT at start of the cycle; load captured during target word's T1 cycle SHALL hit one revolution later (3132 cycles).
REQ-027 LOC_LOAD while WAIT SHALL replace target; old target never hits after the edge.
REQ-028 LOC_LOAD coincident with LOC_HIT: hit pulse still issued, new target captured, state stays WAIT.
REQ-029 LOC_CANCEL SHALL force IDLE at the edge, overriding simultaneous LOC_LOAD; LOC_HIT in that cycle still reflects pre-edge state.
REQ-030 SYNC during WAIT SHALL keep WAIT; hit follows new counter values.

Reset
REQ-031 rst SHALL win over SYNC, LOC_LOAD, LOC_CANCEL.
REQ-032 After rst: TB=0, TW=0, T1=1, T2=0, T29=0, CE=1, ORIGIN=1, state IDLE, LOC_BUSY=0, LOC_HIT=0, LOC_ERR=0, target=0.
REQ-033 rst mid-WAIT SHALL drop the wait with no LOC_HIT pulse.

Verification
REQ-034 rst then 3132 free-run cycles -> T29 pulses 108 times, TW 0..107 then ORIGIN=1 again at cycle 3132; CE toggles each word.
REQ-035 At TW=5,TB=10 assert SYNC -> next cycle TB=0, TW=0, ORIGIN=1.
REQ-036 At TW=0,TB=3 LOC_LOAD LOC=2 -> LOC_BUSY=1 next cycle; LOC_HIT single pulse at TW=2,TB=0 (55 cycles after load edge); LOC_BUSY=0 after.
REQ-037 LOC_LOAD LOC=107 during TW=107,TB=0 -> no hit that cycle; hit at same position 3132 cycles later.
REQ-038 LOC_LOAD LOC=110 -> LOC_ERR=1, LOC_BUSY=0; then LOC=4 -> LOC_ERR=0, wait starts.
REQ-039 WAIT on LOC=50, assert LOC_LOAD LOC=9 with LOC_CANCEL same cycle -> IDLE, no hit at word 9 or 50; rst during a separate WAIT -> no hit.

Source files
------------

// File: rtl/drum_timing.sv
// Drum timing generator: bit/word counters with T1/T2/T29/CE/ORIGIN decodes
// and a word-location wait FSM that pulses LOC_HIT when the target word arrives.
module drum_timing #(
    parameter int WORDS = 108,
    parameter int BITS  = 29
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       SYNC,
    input  logic       LOC_LOAD,
    input  logic [6:0] LOC,
    input  logic       LOC_CANCEL,
    output logic [4:0] TB,
    output logic [6:0] TW,
    output logic       T1,
    output logic       T2,
    output logic       T29,
    output logic       CE,
    output logic       ORIGIN,
    output logic       LOC_BUSY,
    output logic       LOC_HIT,
    output logic       LOC_ERR
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [4:0] TB_LAST = 5'(BITS - 1);
    localparam logic [6:0] TW_LAST = 7'(WORDS - 1);

    logic [4:0] tb_r, tb_nx_s;
    logic [6:0] tw_r, tw_nx_s;
    logic [0:0] state_r, state_nx_s;
    logic [6:0] target_r, target_nx_s;
    logic       err_r, err_nx_s;
    logic       hit_r, hit_nx_s;
    logic       t1_r, t2_r, t29_r, ce_r, origin_r;
    logic       loc_ok_s;

    // Next bit/word counter values; SYNC overrides the normal increment
    always_comb begin
        tb_nx_s = tb_r + 5'd1;
        tw_nx_s = tw_r;
        if (SYNC) begin
            tb_nx_s = 5'd0;
            tw_nx_s = 7'd0;
        end else if (tb_r == TB_LAST) begin
            tb_nx_s = 5'd0;
            if (tw_r == TW_LAST) begin
                tw_nx_s = 7'd0;
            end else begin
                tw_nx_s = tw_r + 7'd1;
            end
        end else begin
            tb_nx_s = tb_r + 5'd1;
            tw_nx_s = tw_r;
        end
    end

    assign loc_ok_s = ({25'd0, LOC} < 32'(WORDS));

    // Location FSM next state; hit_r is the registered hit of the current cycle
    always_comb begin
        state_nx_s  = state_r;
        target_nx_s = target_r;
        err_nx_s    = err_r;
        if (LOC_CANCEL) begin
            state_nx_s = ST_IDLE;
        end else if (LOC_LOAD && loc_ok_s) begin
            state_nx_s  = ST_WAIT;
            target_nx_s = LOC;
            err_nx_s    = 1'b0;
        end else if (LOC_LOAD) begin
            err_nx_s = 1'b1;
            if (hit_r) begin
                state_nx_s = ST_IDLE;
            end else begin
                state_nx_s = state_r;
            end
        end else if (hit_r) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Hit is precomputed from next-cycle values so the output is a flop yet has no added latency
    always_comb begin
        hit_nx_s = (state_nx_s == ST_WAIT) && (tw_nx_s == target_nx_s) && (tb_nx_s == 5'd0);
    end

    // State registers, including registered decodes of the next counter values
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            tb_r     <= 5'd0;
            tw_r     <= 7'd0;
            state_r  <= ST_IDLE;
            target_r <= 7'd0;
            err_r    <= 1'b0;
            hit_r    <= 1'b0;
            t1_r     <= 1'b1;
            t2_r     <= 1'b0;
            t29_r    <= 1'b0;
            ce_r     <= 1'b1;
            origin_r <= 1'b1;
        end else begin
            tb_r     <= tb_nx_s;
            tw_r     <= tw_nx_s;
            state_r  <= state_nx_s;
            target_r <= target_nx_s;
            err_r    <= err_nx_s;
            hit_r    <= hit_nx_s;
            t1_r     <= (tb_nx_s == 5'd0);
            t2_r     <= (tb_nx_s == 5'd1);
            t29_r    <= (tb_nx_s == TB_LAST);
            ce_r     <= ~tw_nx_s[0];
            origin_r <= (tw_nx_s == 7'd0) && (tb_nx_s == 5'd0);
        end
    end

    assign TB       = tb_r;
    assign TW       = tw_r;
    assign T1       = t1_r;
    assign T2       = t2_r;
    assign T29      = t29_r;
    assign CE       = ce_r;
    assign ORIGIN   = origin_r;
    assign LOC_BUSY = (state_r == ST_WAIT);
    assign LOC_HIT  = hit_r;
    assign LOC_ERR  = err_r;

endmodule

// File: tb/tb_drum_timing.sv
// Directed self-checking bench for drum_timing with hand-computed expectations.
module tb_drum_timing;

    logic       CLOCK = 1'b0;
    logic       rst = 1'b1;
    logic       SYNC = 1'b0;
    logic       LOC_LOAD = 1'b0;
    logic [6:0] LOC = 7'd0;
    logic       LOC_CANCEL = 1'b0;
    logic [4:0] TB;
    logic [6:0] TW;
    logic       T1, T2, T29, CE, ORIGIN, LOC_BUSY, LOC_HIT, LOC_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    drum_timing dut (
        .CLOCK(CLOCK), .rst(rst), .SYNC(SYNC), .LOC_LOAD(LOC_LOAD), .LOC(LOC),
        .LOC_CANCEL(LOC_CANCEL), .TB(TB), .TW(TW), .T1(T1), .T2(T2), .T29(T29),
        .CE(CE), .ORIGIN(ORIGIN), .LOC_BUSY(LOC_BUSY), .LOC_HIT(LOC_HIT), .LOC_ERR(LOC_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic goto_pos(input logic [6:0] tw, input logic [4:0] tb);
        int n = 0;
        while (!(TW == tw && TB == tb) && n < 4000) begin
            step();
            n++;
        end
        chk("goto_reached", {31'd0, (TW == tw && TB == tb)}, 32'd1);
    endtask

    task automatic load(input logic [6:0] loc, input logic cancel);
        LOC_LOAD = 1'b1;
        LOC = loc;
        LOC_CANCEL = cancel;
        step();
        LOC_LOAD = 1'b0;
        LOC_CANCEL = 1'b0;
    endtask

    task automatic wait_hit(input int max, output int n);
        n = 0;
        while (!LOC_HIT && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic count_hits(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (LOC_HIT) hits++;
        end
    endtask

    initial begin
        int errs, pulses, n, hits;
        step();
        step();
        rst = 1'b0;
        chk("rst_tb", 32'(TB), 32'd0);
        chk("rst_tw", 32'(TW), 32'd0);
        chk("rst_t1", 32'(T1), 32'd1);
        chk("rst_t2t29", {30'd0, T2, T29}, 32'd0);
        chk("rst_ce_origin", {30'd0, CE, ORIGIN}, 32'd3);
        chk("rst_busy_hit_err", {29'd0, LOC_BUSY, LOC_HIT, LOC_ERR}, 32'd0);

        // One full revolution of free running
        errs = 0;
        pulses = 0;
        for (int i = 0; i < 3132; i++) begin
            if (TB != 5'(i % 29) || TW != 7'(i / 29)) errs++;
            if (T1 != ((i % 29) == 0) || T2 != ((i % 29) == 1)) errs++;
            if (T29 != ((i % 29) == 28)) errs++;
            if (CE != (((i / 29) % 2) == 0)) errs++;
            if (ORIGIN != (i == 0)) errs++;
            if (T29) pulses++;
            step();
        end
        chk("fr_decode_errs", errs, 32'd0);
        chk("fr_t29_pulses", pulses, 32'd108);
        chk("fr_origin_again", {31'd0, ORIGIN}, 32'd1);
        chk("fr_tw_wrap", 32'(TW), 32'd0);

        // SYNC mid-revolution
        goto_pos(7'd5, 5'd10);
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        chk("sync_tbtw", {20'd0, TW, TB}, 32'd0);
        chk("sync_origin", {31'd0, ORIGIN}, 32'd1);

        // Wait for word 2 loaded at (0,3): hit 55 cycles after the load edge
        goto_pos(7'd0, 5'd3);
        load(7'd2, 1'b0);
        chk("l2_busy", {31'd0, LOC_BUSY}, 32'd1);
        hits = LOC_HIT ? 1 : 0;
        for (int i = 0; i < 53; i++) begin
            step();
            if (LOC_HIT) hits++;
        end
        chk("l2_early_hits", hits, 32'd0);
        step();
        chk("l2_hit", {31'd0, LOC_HIT}, 32'd1);
        chk("l2_hit_pos", {20'd0, TW, TB}, {20'd0, 7'd2, 5'd0});
        step();
        chk("l2_after", {30'd0, LOC_HIT, LOC_BUSY}, 32'd0);

        // Load during the target's own T1 hits one revolution later
        goto_pos(7'd107, 5'd0);
        chk("l107_no_hit_now", {31'd0, LOC_HIT}, 32'd0);
        load(7'd107, 1'b0);
        hits = LOC_HIT ? 1 : 0;
        for (int i = 0; i < 3130; i++) begin
            step();
            if (LOC_HIT) hits++;
        end
        chk("l107_early_hits", hits, 32'd0);
        step();
        chk("l107_hit", {31'd0, LOC_HIT}, 32'd1);
        chk("l107_hit_pos", {20'd0, TW, TB}, {20'd0, 7'd107, 5'd0});
        step();

        // Out-of-range request, then a valid one
        load(7'd110, 1'b0);
        chk("err_set", {30'd0, LOC_ERR, LOC_BUSY}, 32'd2);
        load(7'd4, 1'b0);
        chk("err_clr", {30'd0, LOC_ERR, LOC_BUSY}, 32'd1);
        wait_hit(3200, n);
        chk("l4_hit", {31'd0, LOC_HIT}, 32'd1);
        chk("l4_hit_pos", {20'd0, TW, TB}, {20'd0, 7'd4, 5'd0});
        step();
        chk("l4_after_busy", {31'd0, LOC_BUSY}, 32'd0);

        // Retarget while waiting: old word 30 must not hit
        goto_pos(7'd20, 5'd0);
        load(7'd30, 1'b0);
        for (int i = 0; i < 5; i++) step();
        load(7'd40, 1'b0);
        wait_hit(3200, n);
        chk("rt_hit_pos", {20'd0, TW, TB}, {20'd0, 7'd40, 5'd0});

        // Load coincident with a hit: new target captured, stays busy
        load(7'd10, 1'b0);
        wait_hit(3200, n);
        chk("co_first_pos", {20'd0, TW, TB}, {20'd0, 7'd10, 5'd0});
        load(7'd12, 1'b0);
        chk("co_busy", {30'd0, LOC_BUSY, LOC_HIT}, 32'd2);
        wait_hit(3200, n);
        chk("co_gap", n, 32'd57);
        chk("co_hit_pos", {20'd0, TW, TB}, {20'd0, 7'd12, 5'd0});
        step();

        // SYNC during wait for word 0 hits at the forced origin
        goto_pos(7'd60, 5'd5);
        load(7'd0, 1'b0);
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        chk("sw_hit", {29'd0, LOC_HIT, LOC_BUSY, ORIGIN}, 32'd7);
        step();
        chk("sw_after", {31'd0, LOC_BUSY}, 32'd0);

        // Cancel overrides a simultaneous load
        load(7'd50, 1'b0);
        chk("cx_busy", {31'd0, LOC_BUSY}, 32'd1);
        load(7'd9, 1'b1);
        chk("cx_idle", {31'd0, LOC_BUSY}, 32'd0);
        count_hits(3200, hits);
        chk("cx_no_hits", hits, 32'd0);

        // Reset mid-wait drops it silently
        load(7'd20, 1'b0);
        chk("rw_busy", {31'd0, LOC_BUSY}, 32'd1);
        rst = 1'b1;
        LOC_LOAD = 1'b1;
        SYNC = 1'b1;
        LOC = 7'd3;
        step();
        rst = 1'b0;
        LOC_LOAD = 1'b0;
        SYNC = 1'b0;
        chk("rw_state", {29'd0, LOC_BUSY, LOC_HIT, LOC_ERR}, 32'd0);
        chk("rw_pos", {20'd0, TW, TB}, 32'd0);
        count_hits(3200, hits);
        chk("rw_no_hits", hits, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
